// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Port/index helpers work on fixed maximum widths; callers zero-pad their vectors.
package regfile_pkg;

    localparam int unsigned SP_INDEX_DEF = 14;
    localparam logic [31:0] SP_INIT_DEF  = 32'h2000_0000;

    localparam int unsigned MAX_WR     = 8;
    localparam int unsigned MAX_ADDR_W = 8;
    localparam int unsigned MAX_DEPTH  = 256;

    typedef struct packed {
        logic       hit;
        logic [2:0] port;
    } wr_match_t;

    // Highest-index enabled write port whose address equals addr.
    function automatic wr_match_t wr_match(
        input logic [MAX_WR-1:0]            en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
        input logic [MAX_ADDR_W-1:0]        addr
    );
        wr_match_t m;
        m = '0;
        for (int unsigned w = 0; w < MAX_WR; w++) begin
            if (en[w] && (addrs[w*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                m.hit  = 1'b1;
                m.port = 3'(w);
            end
        end
        return m;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-side bus of the register file: read ports, write ports,
// scoreboard controls and debug readout.
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     flush;
    logic [ADDR_W:0]          pending_cnt;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush, dbg_addr,
        input  rd_data, rd_busy, pending_cnt, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush, dbg_addr,
        output rd_data, rd_busy, pending_cnt, dbg_data
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending scoreboard: issue sets, writeback/flush clear,
// busy flags for read ports and a registered pending count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic                     i_issue_en,
    input  logic [ADDR_W-1:0]        i_issue_addr,
    input  logic                     i_flush,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic [ADDR_W:0]          o_pending_cnt
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0]             r_pend;
    logic [DEPTH-1:0]             w_pend_d;
    logic [CNT_W-1:0]             r_cnt;
    logic [MAX_WR-1:0]            w_wr_en_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0] w_wr_addr_pad;

    always_comb begin
        w_wr_en_pad   = MAX_WR'(i_wr_en);
        w_wr_addr_pad = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            w_wr_addr_pad[w*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(i_wr_addr[w*ADDR_W +: ADDR_W]);
        end
    end

    // Applied lowest to highest precedence: flush, then writes, then issue.
    always_comb begin
        w_pend_d = r_pend;
        if (i_flush) begin
            w_pend_d = '0;
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (i_wr_en[w]) begin
                w_pend_d[i_wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (i_issue_en) begin
            w_pend_d[i_issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_pend_d[0] = 1'b0;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_addr;
        wr_match_t         w_m;
        o_rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_addr = i_rd_addr[i*ADDR_W +: ADDR_W];
            w_m    = wr_match(w_wr_en_pad, w_wr_addr_pad, MAX_ADDR_W'(w_addr));
            o_rd_busy[i] = r_pend[w_addr] & ~w_m.hit & ~((ZERO_REG != 0) && (w_addr == '0));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_d;
            r_cnt  <= CNT_W'(popcount(MAX_DEPTH'(w_pend_d)));
        end
    end

    assign o_pending_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// pending scoreboard and a registered debug readout.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned SP_INDEX = SP_INDEX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
    input logic            i_clk,
    input logic            i_reset_n,
    regfile_mp_sb_if.slave bus
);
    logic [DATA_W-1:0]            r_mem [DEPTH];
    logic [DATA_W-1:0]            r_dbg_data;
    logic [MAX_WR-1:0]            w_wr_en_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0] w_wr_addr_pad;
    logic [DATA_W-1:0]            w_wr_data_pad [MAX_WR];
    // Entry NUM_RD is the debug port; it shares the bypass path to get post-write data.
    logic [ADDR_W-1:0]            w_addr [NUM_RD+1];
    logic [DATA_W-1:0]            w_val  [NUM_RD+1];
    logic [NUM_RD-1:0]            w_rd_busy;
    logic [ADDR_W:0]              w_pending_cnt;

    always_comb begin
        w_wr_en_pad   = MAX_WR'(bus.wr_en);
        w_wr_addr_pad = '0;
        w_wr_data_pad = '{default: '0};
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            w_wr_addr_pad[w*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(bus.wr_addr[w*ADDR_W +: ADDR_W]);
            w_wr_data_pad[w] = bus.wr_data[w*DATA_W +: DATA_W];
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign w_addr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign bus.rd_data[i*DATA_W +: DATA_W] = w_val[i];
    end
    assign w_addr[NUM_RD] = bus.dbg_addr;

    always_comb begin
        wr_match_t w_m;
        w_val = '{default: '0};
        for (int unsigned i = 0; i <= NUM_RD; i++) begin
            w_m = wr_match(w_wr_en_pad, w_wr_addr_pad, MAX_ADDR_W'(w_addr[i]));
            if ((ZERO_REG != 0) && (w_addr[i] == '0)) begin
                w_val[i] = '0;
            end else if (w_m.hit) begin
                w_val[i] = w_wr_data_pad[w_m.port];
            end else begin
                w_val[i] = r_mem[w_addr[i]];
            end
        end
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                r_mem[r] <= (r == SP_INDEX) ? SP_INIT : '0;
            end
            r_dbg_data <= '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] &&
                    !((ZERO_REG != 0) && (bus.wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
                    r_mem[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
                end
            end
            r_dbg_data <= w_val[NUM_RD];
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_rd_addr     (bus.rd_addr),
        .i_wr_en       (bus.wr_en),
        .i_wr_addr     (bus.wr_addr),
        .i_issue_en    (bus.issue_en),
        .i_issue_addr  (bus.issue_addr),
        .i_flush       (bus.flush),
        .o_rd_busy     (w_rd_busy),
        .o_pending_cnt (w_pending_cnt)
    );

    assign bus.rd_busy     = w_rd_busy;
    assign bus.pending_cnt = w_pending_cnt;
    assign bus.dbg_data    = r_dbg_data;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a default build and a ZERO_REG=1 build
// driven side by side from one stimulus sequence.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2)) a_if ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .NUM_WR(2)) z_if ();

    regfile_mp_sb #(.ZERO_REG(0)) u_dut_a (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (a_if.slave)
    );

    regfile_mp_sb #(.ZERO_REG(1)) u_dut_z (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (z_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        a_if.wr_en = '0;  a_if.issue_en = 1'b0; a_if.flush = 1'b0;
        z_if.wr_en = '0;  z_if.issue_en = 1'b0; z_if.flush = 1'b0;
    endtask

    initial begin
        a_if.rd_addr = '0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.issue_addr = '0;
        a_if.dbg_addr = '0;
        z_if.rd_addr = '0; z_if.wr_addr = '0; z_if.wr_data = '0; z_if.issue_addr = '0;
        z_if.dbg_addr = '0;
        clear_inputs();

        // Asynchronous reset, no clock edge yet.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_cnt", 32'(a_if.pending_cnt), 32'd0);
        chk("reset_dbg", a_if.dbg_data, 32'd0);
        chk("reset_busy", 32'(a_if.rd_busy), 32'd0);
        for (int r = 0; r < 16; r++) begin
            a_if.rd_addr[3:0] = 4'(r);
            #1;
            chk($sformatf("reset_r%0d", r), a_if.rd_data[31:0],
                (r == 14) ? 32'h2000_0000 : 32'd0);
        end

        // Bypass write r3 on port 0.
        @(negedge clk);
        reset_n = 1'b1;
        a_if.rd_addr = {4'd14, 4'd3};
        a_if.wr_en = 2'b01; a_if.wr_addr = {4'd0, 4'd3}; a_if.wr_data = {32'd0, 32'hDEAD_BEEF};
        #1;
        chk("bypass_same", a_if.rd_data[31:0], 32'hDEAD_BEEF);
        chk("sp_read", a_if.rd_data[63:32], 32'h2000_0000);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("bypass_stored", a_if.rd_data[31:0], 32'hDEAD_BEEF);

        // Collision on r5; debug readout sees the winning value.
        @(negedge clk);
        a_if.rd_addr = {4'd3, 4'd5};
        a_if.wr_en = 2'b11; a_if.wr_addr = {4'd5, 4'd5};
        a_if.wr_data = {32'h0000_2222, 32'h0000_1111};
        a_if.dbg_addr = 4'd5;
        #1;
        chk("collide_bypass", a_if.rd_data[31:0], 32'h0000_2222);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("collide_stored", a_if.rd_data[31:0], 32'h0000_2222);
        chk("dbg_post_write", a_if.dbg_data, 32'h0000_2222);
        chk("r3_kept", a_if.rd_data[63:32], 32'hDEAD_BEEF);

        // Scoreboard: issue r7, two idle cycles, then write r7.
        @(negedge clk);
        a_if.rd_addr = {4'd7, 4'd0};
        a_if.issue_en = 1'b1; a_if.issue_addr = 4'd7;
        #1;
        chk("sb_issue_cycle", 32'(a_if.rd_busy[1]), 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("sb_idle1_busy", 32'(a_if.rd_busy[1]), 32'd1);
        chk("sb_idle1_cnt", 32'(a_if.pending_cnt), 32'd1);
        @(negedge clk);
        #1;
        chk("sb_idle2_busy", 32'(a_if.rd_busy[1]), 32'd1);
        chk("sb_idle2_cnt", 32'(a_if.pending_cnt), 32'd1);
        @(negedge clk);
        a_if.wr_en = 2'b01; a_if.wr_addr = {4'd0, 4'd7}; a_if.wr_data = {32'd0, 32'h55};
        #1;
        chk("sb_write_busy", 32'(a_if.rd_busy[1]), 32'd0);
        chk("sb_write_data", a_if.rd_data[63:32], 32'h55);
        chk("sb_write_cnt", 32'(a_if.pending_cnt), 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("sb_after_cnt", 32'(a_if.pending_cnt), 32'd0);
        chk("sb_after_busy", 32'(a_if.rd_busy[1]), 32'd0);

        // Precedence: pending {r2, r9}; then flush + issue r9 + port-1 write r2.
        @(negedge clk);
        a_if.issue_en = 1'b1; a_if.issue_addr = 4'd2;
        @(negedge clk);
        a_if.issue_addr = 4'd9;
        @(negedge clk);
        a_if.rd_addr = {4'd9, 4'd2};
        a_if.flush = 1'b1; a_if.issue_en = 1'b1; a_if.issue_addr = 4'd9;
        a_if.wr_en = 2'b10; a_if.wr_addr = {4'd2, 4'd0}; a_if.wr_data = {32'h0000_ABCD, 32'd0};
        #1;
        chk("prec_before_cnt", 32'(a_if.pending_cnt), 32'd2);
        chk("prec_busy_r2_bypassed", 32'(a_if.rd_busy[0]), 32'd0);
        chk("prec_busy_r9", 32'(a_if.rd_busy[1]), 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("prec_cnt", 32'(a_if.pending_cnt), 32'd1);
        chk("prec_r2_clear", 32'(a_if.rd_busy[0]), 32'd0);
        chk("prec_r9_set", 32'(a_if.rd_busy[1]), 32'd1);
        chk("prec_r2_data", a_if.rd_data[31:0], 32'h0000_ABCD);
        @(negedge clk);
        a_if.flush = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("flush_cnt", 32'(a_if.pending_cnt), 32'd0);
        chk("flush_busy", 32'(a_if.rd_busy[1]), 32'd0);

        // Reset asserted while a write to r14 is presented: the write is lost.
        @(negedge clk);
        a_if.rd_addr = {4'd14, 4'd3};
        a_if.wr_en = 2'b01; a_if.wr_addr = {4'd0, 4'd14}; a_if.wr_data = {32'd0, 32'h0000_1234};
        #1;
        chk("rst_wr_bypass", a_if.rd_data[63:32], 32'h0000_1234);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_wr_r3", a_if.rd_data[31:0], 32'd0);
        chk("rst_wr_dbg", a_if.dbg_data, 32'd0);
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b1;
        #1;
        chk("rst_wr_r14", a_if.rd_data[63:32], 32'h2000_0000);

        // ZERO_REG build: r0 is constant 0, never pending.
        @(negedge clk);
        z_if.issue_en = 1'b1; z_if.issue_addr = 4'd4;
        @(negedge clk);
        z_if.rd_addr = {4'd4, 4'd0};
        z_if.dbg_addr = 4'd0;
        z_if.wr_en = 2'b01; z_if.wr_addr = {4'd0, 4'd0}; z_if.wr_data = {32'd0, 32'hFFFF_FFFF};
        z_if.issue_en = 1'b1; z_if.issue_addr = 4'd0;
        a_if.rd_addr = {4'd0, 4'd0};
        a_if.wr_en = 2'b01; a_if.wr_addr = {4'd0, 4'd0}; a_if.wr_data = {32'd0, 32'h77};
        #1;
        chk("z_r0_bypass", z_if.rd_data[31:0], 32'd0);
        chk("z_r0_busy", 32'(z_if.rd_busy[0]), 32'd0);
        chk("z_r4_busy", 32'(z_if.rd_busy[1]), 32'd1);
        chk("z_cnt_before", 32'(z_if.pending_cnt), 32'd1);
        chk("a_r0_bypass", a_if.rd_data[31:0], 32'h77);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("z_r0_stored", z_if.rd_data[31:0], 32'd0);
        chk("z_r0_busy_after", 32'(z_if.rd_busy[0]), 32'd0);
        chk("z_cnt_after", 32'(z_if.pending_cnt), 32'd1);
        chk("z_dbg_r0", z_if.dbg_data, 32'd0);
        chk("a_r0_stored", a_if.rd_data[31:0], 32'h77);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined core.
- Sits between decode (reads, issue) and writeback (writes).
- Generalises the single-write, two-read file with:
  - N read ports and M write ports
  - write-to-read bypass
  - optional hard-wired zero register
  - a per-register pending scoreboard for hazard stalls
  - a registered debug readout.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 16, number of architectural registers (power of two)
- ADDR_W, $clog2(DEPTH), register index width
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes
- SP_INDEX, 14, register given a non-zero reset value
- SP_INIT, 32'h2000_0000, reset value of register SP_INDEX

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i uses slice [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  source register pending and not bypassed this cycle
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  write indices
- wr_data  in  NUM_WR*DATA_W  write data
- issue_en  in  1  mark issue_addr as pending (new producer in flight)
- issue_addr  in  ADDR_W  destination of issued instruction
- flush  in  1  clear all pending bits (pipeline squash)
- pending_cnt  out  ADDR_W+1  registered count of pending registers
- dbg_addr  in  ADDR_W  debug readout index
- dbg_data  out  DATA_W  registered debug readout

Behaviour:
- Reset (reset_n low, asynchronous):
  - all registers 0, except register SP_INDEX = SP_INIT
  - all pending bits 0; pending_cnt = 0; dbg_data = 0
  - Holds while low; deassertion is synchronous to clk (caller's responsibility).
  - Reset mid-write discards the write.
- Writes:
  - On rising edge, each port w with wr_en[w]=1 writes wr_data[w] to wr_addr[w].
  - Same-address collision between ports: the highest-index port wins.
  - ZERO_REG=1: writes to index 0 are dropped. They still clear pending[0].
- Reads are combinational. For each read port i:
  - if ZERO_REG=1 and rd_addr=0, rd_data = 0
  - else if any enabled write port matches rd_addr, rd_data = that port's wr_data (highest index wins), i.e. zero-latency bypass
  - else rd_data = stored value.
- Scoreboard (pending bit per register), next state per register r:
  - cleared if flush=1
  - cleared if any enabled write matches r
  - set if issue_en=1 and issue_addr=r
  - Precedence: issue set > write clear > flush clear. A same-cycle issue to r survives both flush and a write to r.
  - ZERO_REG=1: pending[0] is never set.
- rd_busy[i] = pending[rd_addr[i]] and not (an enabled write this cycle matches rd_addr[i]). Forced 0 for index 0 when ZERO_REG=1.
- pending_cnt: registered popcount of the next-state pending vector. It equals the number of set bits visible in the cycle after the edge. Range 0..DEPTH.
- dbg_data: on each rising edge, loads the post-write value of register dbg_addr, i.e. the value the register holds after that same edge. One-cycle latency.
- No X propagation: every output is defined for every input combination after reset.

Decomposition:
- Shared package regfile_pkg:
  - reset constants SP_INDEX_DEF, SP_INIT_DEF
  - a function for highest-priority write-port match, returning a hit bit and port index
  - a popcount function.
- One sub-module, regfile_scoreboard: pending vector, rd_busy generation and pending_cnt. Parameters DEPTH, ADDR_W, NUM_RD, NUM_WR, ZERO_REG.
- The storage array, write logic, bypass and debug register stay in the top module.

Test Plan:
- Reset check: drop reset_n mid-cycle with no clk edge.
  - rd_data reads 0 for r0..r13 and r15, and 32'h2000_0000 for r14.
  - pending_cnt = 0; dbg_data = 0, all immediately.
- Bypass: write r3=0xDEAD_BEEF on port 0 while rd_addr[0]=3.
  - rd_data[0] = 0xDEAD_BEEF in the same cycle.
  - Next cycle, with wr_en=0, it still reads 0xDEAD_BEEF.
- Write collision: port 0 writes r5=0x1111, port 1 writes r5=0x2222 on the same edge.
  - r5 = 0x2222; same-cycle bypass read of r5 = 0x2222.
- Scoreboard: issue r7, then 2 idle cycles, then write r7=0x55.
  - rd_busy for r7 = 1 during the idle cycles and 0 in the write cycle.
  - pending_cnt = 1, then 0.
- Precedence: set pending r2 and r9, then one edge with flush=1, issue_en=1 to r9, and a port-1 write to r2.
  - pending = {r9} only; pending_cnt = 1.
- ZERO_REG=1 build: write r0=0xFFFF_FFFF and issue r0.
  - rd_data for r0 = 0; rd_busy = 0; pending_cnt unchanged.
  - dbg_addr=0 yields dbg_data = 0 one cycle later.
